// File: rtl/mux_pipe_n.sv
// ============================================================================
// Module  : mux_pipe_n
// Brief   : N-way WIDTH-bit select mux feeding a 2-entry (main + skid)
//           valid/ready output buffer with flush and out-of-range select flag.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_pipe_n #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data_i,
  input  logic [SELW-1:0]      in_sel_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 flush_i,
  output logic [WIDTH-1:0]     out_data_o,
  output logic [SELW-1:0]      out_sel_o,
  output logic                 out_err_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i
);

  // Buffered beat layout: {err, sel, data}
  localparam int            c_BW = WIDTH + SELW + 1;
  localparam logic [SELW:0] c_N  = (SELW + 1)'(N);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [c_BW-1:0]   main_q,  main_d;
  logic [c_BW-1:0]   skid_q,  skid_d;

  logic [WIDTH-1:0]  w_word;
  logic              w_err;
  logic [c_BW-1:0]   w_beat;
  logic              w_accept;
  logic              w_pop;

  // Only the addressed slice is ever routed, so X on idle channels stays out.
  always_comb begin
    w_word = '0;
    for (int k = 0; k < N; k++) begin
      if (in_sel_i == SELW'(k)) begin
        w_word = in_data_i[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_err  = ({1'b0, in_sel_i} >= c_N);
  assign w_beat = {w_err, in_sel_i, w_word};

  assign in_ready_o  = ~rst & (state_q != S_FULL);
  assign out_valid_o = (state_q != S_EMPTY);
  assign w_accept    = in_valid_i & in_ready_o;
  assign w_pop       = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (w_accept) begin
          main_d  = w_beat;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (w_accept && w_pop) begin
          main_d = w_beat;
        end else if (w_accept) begin
          skid_d  = w_beat;
          state_d = S_FULL;
        end else if (w_pop) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_pop) begin
          main_d  = skid_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    // Flush overrides everything; data regs may keep stale contents.
    if (flush_i) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign out_data_o = main_q[WIDTH-1:0];
  assign out_sel_o  = main_q[WIDTH +: SELW];
  assign out_err_o  = main_q[c_BW-1];

endmodule

`default_nettype wire

// File: tb/tb_mux_pipe_n.sv
// ============================================================================
// Module  : tb_mux_pipe_n
// Brief   : Self-checking bench for mux_pipe_n (N=4 and N=3 instances).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mux_pipe_n;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic [127:0] in_data;
  logic [1:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic         flush;
  logic [31:0]  out_data;
  logic [1:0]   out_sel;
  logic         out_err;
  logic         out_valid;
  logic         out_ready;

  logic [95:0]  in_data3;
  logic [1:0]   in_sel3;
  logic         in_valid3;
  logic         in_ready3;
  logic         flush3;
  logic [31:0]  out_data3;
  logic [1:0]   out_sel3;
  logic         out_err3;
  logic         out_valid3;
  logic         out_ready3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_pipe_n #(.WIDTH(32), .N(4), .SELW(2)) dut (
    .clk(clk), .rst(rst),
    .in_data_i(in_data), .in_sel_i(in_sel), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .flush_i(flush),
    .out_data_o(out_data), .out_sel_o(out_sel), .out_err_o(out_err),
    .out_valid_o(out_valid), .out_ready_i(out_ready)
  );

  mux_pipe_n #(.WIDTH(32), .N(3), .SELW(2)) dut3 (
    .clk(clk), .rst(rst),
    .in_data_i(in_data3), .in_sel_i(in_sel3), .in_valid_i(in_valid3),
    .in_ready_o(in_ready3), .flush_i(flush3),
    .out_data_o(out_data3), .out_sel_o(out_sel3), .out_err_o(out_err3),
    .out_valid_o(out_valid3), .out_ready_i(out_ready3)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: pick channel sel of n, or flag error with zero data.
  function automatic logic [34:0] ref_beat(input logic [127:0] d, input int sel, input int n);
    logic [127:0] sh;
    if (sel >= n) return {1'b1, 2'(sel), 32'h0};
    sh = d >> (32 * sel);
    return {1'b0, 2'(sel), sh[31:0]};
  endfunction

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t        tbl[8];
  logic [34:0] q[$];
  logic        acc, pop;

  initial begin
    tbl[0] = '{2'd0, 32'hC000_0000, 1'b0};
    tbl[1] = '{2'd3, 32'h0000_0000, 1'b1};
    tbl[2] = '{2'd0, 32'hC000_0000, 1'b0};
    tbl[3] = '{2'd2, 32'hC000_0222, 1'b0};
    tbl[4] = '{2'd1, 32'hC000_0111, 1'b0};
    tbl[5] = '{2'd3, 32'h0000_0000, 1'b1};
    tbl[6] = '{2'd3, 32'h0000_0000, 1'b1};
    tbl[7] = '{2'd2, 32'hC000_0222, 1'b0};

    in_data   = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    in_sel    = 2'd0;
    in_valid  = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    in_data3  = {32'hC000_0222, 32'hC000_0111, 32'hC000_0000};
    in_sel3   = 2'd0;
    in_valid3 = 1'b1;
    flush3    = 1'b0;
    out_ready3 = 1'b1;

    // Reset held with traffic offered
    repeat (3) begin
      step();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
    end
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_in_ready3", in_ready3, 0);
    in_valid  = 1'b0;
    in_valid3 = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_in_ready3", in_ready3, 1);

    // Select sweep, back-to-back with out_ready=1
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_sel = 2'(k);
      step();
      chk("sweep_valid", out_valid, 1);
      chk("sweep_data", out_data, 32'hA000_0000 + k);
      chk("sweep_sel", out_sel, k);
      chk("sweep_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    chk("sweep_drain", out_valid, 0);

    // Backpressure: fill to FULL, third beat refused
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd1;
    step();
    chk("bp_one_ready", in_ready, 1);
    in_sel = 2'd2;
    step();
    chk("bp_full_ready", in_ready, 0);
    chk("bp_full_sel", out_sel, 1);
    in_sel = 2'd3;
    step();
    chk("bp_hold_sel", out_sel, 1);
    chk("bp_hold_data", out_data, 32'hA000_0001);
    chk("bp_hold_ready", in_ready, 0);
    out_ready = 1'b1;
    step();
    chk("bp_pop1_sel", out_sel, 2);
    chk("bp_pop1_data", out_data, 32'hA000_0002);
    chk("bp_pop1_ready", in_ready, 1);
    step();
    chk("bp_pop2_sel", out_sel, 3);
    chk("bp_pop2_data", out_data, 32'hA000_0003);
    chk("bp_pop2_valid", out_valid, 1);
    in_valid = 1'b0;
    step();
    chk("bp_drain", out_valid, 0);

    // Invalid select on N=3 instance, table driven
    in_valid3 = 1'b1;
    foreach (tbl[i]) begin
      in_sel3 = tbl[i].sel;
      step();
      chk("tbl_valid", out_valid3, 1);
      chk("tbl_data", out_data3, tbl[i].exp_data);
      chk("tbl_sel", out_sel3, tbl[i].sel);
      chk("tbl_err", out_err3, tbl[i].exp_err);
    end
    in_valid3 = 1'b0;
    step();
    chk("tbl_drain", out_valid3, 0);

    // Flush in FULL while offering a beat and popping
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    step();
    in_sel = 2'd1;
    step();
    chk("fl_full", in_ready, 0);
    flush     = 1'b1;
    out_ready = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 1);
    in_data  = {96'h0, 32'h0000_1234};
    in_sel   = 2'd0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chk("fl_after_valid", out_valid, 1);
    chk("fl_after_data", out_data, 32'h0000_1234);
    out_ready = 1'b1;
    step();
    chk("fl_after_alone", out_valid, 0);

    // Flush in ONE with an accepted beat: the beat is dropped
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_one_drop", out_valid, 0);
    step();
    chk("fl_one_stay", out_valid, 0);

    // Randomized traffic vs queue model
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 99) == 0);
      @(negedge clk);
      chk("rnd_in_ready", in_ready, q.size() < 2);
      chk("rnd_out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) chk("rnd_beat", {out_err, out_sel, out_data}, q[0]);
      acc = in_valid && (q.size() < 2);
      pop = (q.size() != 0) && out_ready;
      @(posedge clk);
      if (flush) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(ref_beat(in_data, int'(in_sel), 4));
      end
      #1;
    end
    flush = 1'b0;

    // Async reset with beats buffered
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    step();
    chk("mid_pre_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_err", out_err, 0);
    step();
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rel_ready", in_ready, 1);
    step();
    chk("mid_no_partial", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
